// File: rtl/mdr_pkg.sv
// Shared types and default sizing for the MDR memory port.
package mdr_pkg;

  localparam int unsigned MDR_DATA_W   = 32;
  localparam int unsigned MDR_WAIT_MAX = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_e;

endpackage

// File: rtl/mdr_mem_port_if.sv
// Bus bundle between the datapath/memory side and the MDR port.
interface mdr_mem_port_if
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W = MDR_DATA_W
) ();

  logic              enable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] BusMuxOut;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_ready;
  logic [DATA_W-1:0] qOut;
  logic [DATA_W-1:0] Mdataout;
  logic              mem_rd;
  logic              mem_wr;
  logic              busy;
  logic              done;
  logic              err;

  // Requester / memory side
  modport master (
    output enable, read, write, BusMuxOut, Mdatain, mem_ready,
    input  qOut, Mdataout, mem_rd, mem_wr, busy, done, err
  );

  // MDR port side
  modport slave (
    input  enable, read, write, BusMuxOut, Mdatain, mem_ready,
    output qOut, Mdataout, mem_rd, mem_wr, busy, done, err
  );

endinterface

// File: rtl/mdr_wait_timer.sv
// Counts cycles spent waiting on memory; flags the cycle on which the
// WAIT_MAX-th wait edge is about to occur.
module mdr_wait_timer
  import mdr_pkg::*;
#(
  parameter int unsigned WAIT_MAX = MDR_WAIT_MAX
) (
  input  logic clk,
  input  logic clr,
  input  logic counting,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt;

  // Cleared whenever no transaction is outstanding, so each wait starts at 0
  always_ff @(posedge clk) begin
    if (clr || !counting) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = counting && (cnt == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with a single-outstanding read/write handshake.
// Optional wait timeout is built when MDR_TIMEOUT_EN is defined; without it
// the port waits for mem_ready indefinitely and err stays low.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int unsigned       DATA_W   = MDR_DATA_W,
  parameter logic [DATA_W-1:0] VAL      = '0,
  parameter int unsigned       WAIT_MAX = MDR_WAIT_MAX
) (
  input logic           clk,
  input logic           clr,
  mdr_mem_port_if.slave bus
);

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("mdr_mem_port: WAIT_MAX must be at least 1");
  end

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] q_r, q_d;
  logic [DATA_W-1:0] mdo_r, mdo_d;
  logic              rd_r, rd_d;
  logic              wr_r, wr_d;
  logic              done_r, done_d;
  logic              err_r, err_d;
  logic              busy_r, busy_d;
  logic              timeout_c;

`ifdef MDR_TIMEOUT_EN
  // Abort timer, active only while a transaction is outstanding
  mdr_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .clr       (clr),
    .counting  (state_q != IDLE),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      q_r     <= VAL;
      mdo_r   <= '0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_r     <= q_d;
      mdo_r   <= mdo_d;
      rd_r    <= rd_d;
      wr_r    <= wr_d;
      done_r  <= done_d;
      err_r   <= err_d;
      busy_r  <= busy_d;
    end
  end

  // Next state: IDLE arbitrates read > write > enable; wait states ignore
  // new requests and leave on mem_ready (which beats a coincident timeout)
  always_comb begin
    state_d = state_q;
    q_d     = q_r;
    mdo_d   = mdo_r;
    rd_d    = rd_r;
    wr_d    = wr_r;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read) begin
          state_d = RD_WAIT;
          rd_d    = 1'b1;
        end else if (bus.write) begin
          state_d = WR_WAIT;
          wr_d    = 1'b1;
          mdo_d   = q_r;
        end else if (bus.enable) begin
          q_d = bus.BusMuxOut;
        end
      end
      RD_WAIT: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          q_d     = bus.Mdatain;
          rd_d    = 1'b0;
          done_d  = 1'b1;
        end else if (timeout_c) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      WR_WAIT: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          done_d  = 1'b1;
        end else if (timeout_c) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.qOut     = q_r;
  assign bus.Mdataout = mdo_r;
  assign bus.mem_rd   = rd_r;
  assign bus.mem_wr   = wr_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Bench for mdr_mem_port: directed scenarios plus randomized transactions
// checked against a transaction-level expectation of register contents.
module tb_mdr_mem_port;
  import mdr_pkg::*;

  localparam int unsigned       DW      = 32;
  localparam logic [DW-1:0]     RST_VAL = 32'h0000_00A5;
  localparam int unsigned       WMAX    = 8;

  // flag vector order: {busy, mem_rd, mem_wr, done, err}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RD   = 5'b11000;
  localparam logic [4:0] F_WR   = 5'b10100;
  localparam logic [4:0] F_DONE = 5'b00010;
  localparam logic [4:0] F_ERR  = 5'b00001;

  logic clk = 1'b0;
  logic clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_q;
  logic [DW-1:0] ref_mdo;

  mdr_mem_port_if #(.DATA_W(DW)) bus ();

  mdr_mem_port #(
    .DATA_W   (DW),
    .VAL      (RST_VAL),
    .WAIT_MAX (WMAX)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {bus.busy, bus.mem_rd, bus.mem_wr, bus.done, bus.err};
  endfunction

  task automatic idle_inputs();
    bus.enable    = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.BusMuxOut = '0;
    bus.Mdatain   = '0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    idle_inputs();
    bus.read = 1'b1;
    step();
    step();
    n_cmp++; if (bus.qOut !== RST_VAL) begin n_bad++; $display("FAIL reset_qout: got %h expected %h", bus.qOut, RST_VAL); end
    n_cmp++; if (bus.Mdataout !== '0) begin n_bad++; $display("FAIL reset_mdataout: got %h expected 0", bus.Mdataout); end
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", flags(), F_IDLE); end
    clr = 1'b0;
    bus.read = 1'b0;
    ref_q   = RST_VAL;
    ref_mdo = '0;
  endtask

  task automatic test_write();
    int wr_hi;
    bus.enable    = 1'b1;
    bus.BusMuxOut = 32'h1234_5678;
    step();
    bus.enable = 1'b0;
    ref_q = 32'h1234_5678;
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL wr_enable_load: got %h expected %h", bus.qOut, ref_q); end
    bus.write = 1'b1;
    step();
    bus.write = 1'b0;
    ref_mdo = ref_q;
    wr_hi = 0;
    n_cmp++; if (flags() !== F_WR) begin n_bad++; $display("FAIL wr_request_flags: got %b expected %b", flags(), F_WR); end
    n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL wr_request_data: got %h expected %h", bus.Mdataout, ref_mdo); end
    if (bus.mem_wr === 1'b1) wr_hi++;
    for (int k = 1; k <= 3; k++) begin
      bus.mem_ready = (k == 3);
      bus.BusMuxOut = 32'hFFFF_0000;
      bus.enable    = 1'b1;
      step();
      if (bus.mem_wr === 1'b1) wr_hi++;
      n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL wr_hold_data k=%0d: got %h expected %h", k, bus.Mdataout, ref_mdo); end
      if (k < 3) begin
        n_cmp++; if (flags() !== F_WR) begin n_bad++; $display("FAIL wr_wait_flags k=%0d: got %b expected %b", k, flags(), F_WR); end
      end else begin
        n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL wr_done_flags: got %b expected %b", flags(), F_DONE); end
      end
    end
    idle_inputs();
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL wr_qout_kept: got %h expected %h", bus.qOut, ref_q); end
    step();
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL wr_done_pulse: got %b expected %b", flags(), F_IDLE); end
    n_cmp++; if (wr_hi !== 3) begin n_bad++; $display("FAIL wr_strobe_cycles: got %0d expected 3", wr_hi); end
  endtask

  task automatic test_read();
    bus.read    = 1'b1;
    bus.Mdatain = 32'hDEAD_BEEF;
    step();
    bus.read      = 1'b0;
    bus.mem_ready = 1'b1;
    n_cmp++; if (flags() !== F_RD) begin n_bad++; $display("FAIL rd_request_flags: got %b expected %b", flags(), F_RD); end
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rd_qout_early: got %h expected %h", bus.qOut, ref_q); end
    step();
    bus.mem_ready = 1'b0;
    ref_q = 32'hDEAD_BEEF;
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rd_qout: got %h expected %h", bus.qOut, ref_q); end
    n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL rd_done_flags: got %b expected %b", flags(), F_DONE); end
    step();
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL rd_done_pulse: got %b expected %b", flags(), F_IDLE); end
    idle_inputs();
  endtask

  task automatic test_priority();
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.enable    = 1'b1;
    bus.BusMuxOut = 32'h0BAD_F00D;
    step();
    idle_inputs();
    n_cmp++; if (flags() !== F_RD) begin n_bad++; $display("FAIL prio_flags: got %b expected %b", flags(), F_RD); end
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL prio_qout: got %h expected %h", bus.qOut, ref_q); end
    n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL prio_mdataout: got %h expected %h", bus.Mdataout, ref_mdo); end
    bus.mem_ready = 1'b1;
    bus.Mdatain   = 32'h5A5A_0001;
    step();
    ref_q = 32'h5A5A_0001;
    idle_inputs();
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL prio_complete: got %h expected %h", bus.qOut, ref_q); end
  endtask

  task automatic test_back_to_back();
    bus.read = 1'b1;
    step();
    bus.read      = 1'b0;
    bus.mem_ready = 1'b1;
    bus.Mdatain   = 32'h0000_1111;
    bus.write     = 1'b1;
    step();
    ref_q = 32'h0000_1111;
    bus.mem_ready = 1'b0;
    n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL b2b_not_same_edge: got %b expected %b", flags(), F_DONE); end
    step();
    bus.write = 1'b0;
    ref_mdo = ref_q;
    n_cmp++; if (flags() !== F_WR) begin n_bad++; $display("FAIL b2b_next_edge: got %b expected %b", flags(), F_WR); end
    n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL b2b_mdataout: got %h expected %h", bus.Mdataout, ref_mdo); end
    bus.read      = 1'b1;
    bus.enable    = 1'b1;
    bus.BusMuxOut = 32'h7777_7777;
    step();
    n_cmp++; if (flags() !== F_WR) begin n_bad++; $display("FAIL b2b_ignore_flags: got %b expected %b", flags(), F_WR); end
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL b2b_ignore_qout: got %h expected %h", bus.qOut, ref_q); end
    idle_inputs();
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL b2b_wr_done: got %b expected %b", flags(), F_DONE); end
    step();
  endtask

`ifdef MDR_TIMEOUT_EN
  task automatic test_timeout();
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    for (int k = 1; k <= int'(WMAX); k++) begin
      step();
      if (k < int'(WMAX)) begin
        n_cmp++; if (flags() !== F_RD) begin n_bad++; $display("FAIL to_wait k=%0d: got %b expected %b", k, flags(), F_RD); end
      end else begin
        n_cmp++; if (flags() !== F_ERR) begin n_bad++; $display("FAIL to_abort: got %b expected %b", flags(), F_ERR); end
        n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL to_qout: got %h expected %h", bus.qOut, ref_q); end
      end
    end
    step();
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL to_err_pulse: got %b expected %b", flags(), F_IDLE); end
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    for (int k = 1; k <= int'(WMAX); k++) begin
      bus.mem_ready = (k == int'(WMAX));
      bus.Mdatain   = 32'hC0DE_0008;
      step();
    end
    ref_q = 32'hC0DE_0008;
    idle_inputs();
    n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL to_ready_wins: got %b expected %b", flags(), F_DONE); end
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL to_ready_data: got %h expected %h", bus.qOut, ref_q); end
    step();
  endtask
`else
  task automatic test_timeout();
    bus.write = 1'b1;
    step();
    bus.write = 1'b0;
    ref_mdo = ref_q;
    for (int k = 1; k <= int'(3 * WMAX); k++) begin
      step();
      n_cmp++; if (flags() !== F_WR) begin n_bad++; $display("FAIL nto_wait k=%0d: got %b expected %b", k, flags(), F_WR); end
    end
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL nto_done: got %b expected %b", flags(), F_DONE); end
    step();
  endtask
`endif

  task automatic test_clr_mid();
    bus.read    = 1'b1;
    bus.Mdatain = 32'h9999_9999;
    step();
    bus.read = 1'b0;
    step();
    clr           = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    clr = 1'b0;
    idle_inputs();
    ref_q   = RST_VAL;
    ref_mdo = '0;
    n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL clr_qout: got %h expected %h", bus.qOut, ref_q); end
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL clr_flags: got %b expected %b", flags(), F_IDLE); end
    n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL clr_mdataout: got %h expected %h", bus.Mdataout, ref_mdo); end
    step();
    n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL clr_after: got %b expected %b", flags(), F_IDLE); end
  endtask

  task automatic test_random();
    int unsigned   op;
    int unsigned   lat;
    logic [DW-1:0] d;
    logic [DW-1:0] rdat;
    logic [4:0]    busy_f;
    for (int t = 0; t < 80; t++) begin
      op  = $urandom_range(0, 3);
      lat = $urandom_range(1, 5);
      d   = $urandom;
      if (op == 0) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.Mdatain   = d;
        step();
        idle_inputs();
        n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL rnd_idle_flags t=%0d: got %b expected %b", t, flags(), F_IDLE); end
        n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rnd_idle_qout t=%0d: got %h expected %h", t, bus.qOut, ref_q); end
      end else if (op == 1) begin
        bus.enable    = 1'b1;
        bus.BusMuxOut = d;
        step();
        idle_inputs();
        ref_q = d;
        n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rnd_en_qout t=%0d: got %h expected %h", t, bus.qOut, ref_q); end
        n_cmp++; if (flags() !== F_IDLE) begin n_bad++; $display("FAIL rnd_en_flags t=%0d: got %b expected %b", t, flags(), F_IDLE); end
      end else begin
        if (op == 2) begin
          bus.read   = 1'b1;
          bus.write  = 1'($urandom_range(0, 1));
          bus.enable = 1'($urandom_range(0, 1));
          busy_f     = F_RD;
        end else begin
          bus.write  = 1'b1;
          bus.enable = 1'($urandom_range(0, 1));
          busy_f     = F_WR;
          ref_mdo    = ref_q;
        end
        bus.BusMuxOut = d;
        step();
        idle_inputs();
        n_cmp++; if (flags() !== busy_f) begin n_bad++; $display("FAIL rnd_req_flags t=%0d: got %b expected %b", t, flags(), busy_f); end
        n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rnd_req_qout t=%0d: got %h expected %h", t, bus.qOut, ref_q); end
        for (int k = 1; k <= int'(lat); k++) begin
          rdat          = $urandom;
          bus.Mdatain   = rdat;
          bus.mem_ready = (k == int'(lat));
          bus.read      = 1'($urandom_range(0, 1));
          bus.write     = 1'($urandom_range(0, 1));
          bus.enable    = 1'($urandom_range(0, 1));
          bus.BusMuxOut = $urandom;
          step();
          if (k == int'(lat)) begin
            if (op == 2) ref_q = rdat;
            n_cmp++; if (flags() !== F_DONE) begin n_bad++; $display("FAIL rnd_done t=%0d: got %b expected %b", t, flags(), F_DONE); end
          end else begin
            n_cmp++; if (flags() !== busy_f) begin n_bad++; $display("FAIL rnd_wait t=%0d k=%0d: got %b expected %b", t, k, flags(), busy_f); end
          end
          n_cmp++; if (bus.qOut !== ref_q) begin n_bad++; $display("FAIL rnd_wait_qout t=%0d k=%0d: got %h expected %h", t, k, bus.qOut, ref_q); end
          n_cmp++; if (bus.Mdataout !== ref_mdo) begin n_bad++; $display("FAIL rnd_mdataout t=%0d k=%0d: got %h expected %h", t, k, bus.Mdataout, ref_mdo); end
        end
        idle_inputs();
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    idle_inputs();
    ref_q   = RST_VAL;
    ref_mdo = '0;
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_clr_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
